// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: default widths, gain-compensation latency and the
// shift-add decomposition of 1/K = 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13 - 2^-15 - 2^-16.
package cordic_pkg;
  localparam int CORDIC_WIDTH_DEF  = 22;
  localparam int ROT_BITS_DEF      = 16;
  localparam int GAIN_COMP_LATENCY = 3;

  // Term i uses shift TERM_SHIFT[i]; TERM_NEG[i] set means the term is subtracted.
  localparam int NUM_TERMS = 7;
  localparam logic [NUM_TERMS-1:0][4:0] TERM_SHIFT =
    {5'd16, 5'd15, 5'd13, 5'd9, 5'd6, 5'd3, 5'd1};
  localparam logic [NUM_TERMS-1:0] TERM_NEG = 7'b1111100;
endpackage

// File: rtl/vec_gain_shift_term.sv
// One coefficient term of the 1/K shift-add: x >>> SHIFT (truncate toward -inf),
// or round-half-up (x + 2^(SHIFT-1)) >>> SHIFT when VEC_GAIN_ROUND_EN is defined.
// Purely combinational; the caller provides one guard bit of headroom in W.
module vec_gain_shift_term #(
  parameter int W     = 23,
  parameter int SHIFT = 1
) (
  input  logic signed [W-1:0] x_i,
  output logic signed [W-1:0] term_o
);
`ifdef VEC_GAIN_ROUND_EN
  localparam logic [W-1:0] HALF = {{(W-1){1'b0}}, 1'b1} << (SHIFT-1);
  assign term_o = (x_i + $signed(HALF)) >>> SHIFT;
`else
  assign term_o = x_i >>> SHIFT;
`endif
endmodule

// File: rtl/vec_gain_comp.sv
// CORDIC gain compensation: mag_out = x_in * 1/K via a 3-stage shift-add
// pipeline, with direction bits delayed alongside and a global downstream hold.
// Optional build macro: VEC_GAIN_ROUND_EN (round-half-up on every shifted term).
module vec_gain_comp
  import cordic_pkg::*;
#(
  parameter int CORDIC_WIDTH = CORDIC_WIDTH_DEF,
  parameter int ROT_BITS     = ROT_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [CORDIC_WIDTH-1:0] x_in,
  input  logic [ROT_BITS-1:0]     rot_dir_in,
  input  logic                    hold,
  output logic                    in_ready,
  output logic [CORDIC_WIDTH-1:0] mag_out,
  output logic [ROT_BITS-1:0]     rot_dir_out,
  output logic                    op_valid
);
  // One guard bit: positive coefficients sum to < 1, so nothing can overflow.
  localparam int IW = CORDIC_WIDTH + 1;

  logic signed [IW-1:0] x_ext;
  logic signed [IW-1:0] term  [NUM_TERMS];
  logic signed [IW-1:0] sterm [NUM_TERMS];

  assign x_ext    = {x_in[CORDIC_WIDTH-1], x_in};
  assign in_ready = ~hold;

  // Subtracted terms are negated here, so the N1/N2 registers carry -N1/-N2
  // and every later stage is a plain add (bit-identical to P - N1 - N2).
  for (genvar g = 0; g < NUM_TERMS; g++) begin : g_term
    vec_gain_shift_term #(.W(IW), .SHIFT(int'(TERM_SHIFT[g]))) u_term (
      .x_i    (x_ext),
      .term_o (term[g])
    );
    assign sterm[g] = TERM_NEG[g] ? -term[g] : term[g];
  end

  logic signed [IW-1:0]       p_d, n1_d, n2_d, a_d, sum_d;
  logic signed [IW-1:0]       p_q, n1_q, n2_q, a_q, b_q;
  logic [CORDIC_WIDTH-1:0]    mag_q;
  logic [ROT_BITS-1:0]        dir_s1_q, dir_s2_q, dir_q;
  logic [GAIN_COMP_LATENCY-1:0] vld_q;

  // Stage adders: stage 1 groups terms, stage 2 folds P and N1, stage 3 final sum.
  always_comb begin
    p_d   = sterm[0] + sterm[1];
    n1_d  = sterm[2] + sterm[3];
    n2_d  = sterm[4] + sterm[5] + sterm[6];
    a_d   = p_q + n1_q;
    sum_d = a_q + b_q;
  end

  // Pipeline registers; data loads on every unheld cycle, valid is a plain shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q      <= '0;
      n1_q     <= '0;
      n2_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mag_q    <= '0;
      dir_s1_q <= '0;
      dir_s2_q <= '0;
      dir_q    <= '0;
      vld_q    <= '0;
    end else if (!hold) begin
      p_q      <= p_d;
      n1_q     <= n1_d;
      n2_q     <= n2_d;
      dir_s1_q <= rot_dir_in;
      a_q      <= a_d;
      b_q      <= n2_q;
      dir_s2_q <= dir_s1_q;
      mag_q    <= sum_d[CORDIC_WIDTH-1:0];
      dir_q    <= dir_s2_q;
      vld_q    <= {vld_q[GAIN_COMP_LATENCY-2:0], enable};
    end
  end

  assign mag_out     = mag_q;
  assign rot_dir_out = dir_q;
  assign op_valid    = vld_q[GAIN_COMP_LATENCY-1];
endmodule

// File: tb/tb_vec_gain_comp.sv
// Directed bench for vec_gain_comp: latency, stream alignment, hold, async
// reset and extremes against hand values and an independent integer model.
module tb_vec_gain_comp;
  localparam int CW = 22;
  localparam int RB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [CW-1:0] x_in;
  logic [RB-1:0] rot_dir_in;
  logic          hold;
  logic          in_ready;
  logic [CW-1:0] mag_out;
  logic [RB-1:0] rot_dir_out;
  logic          op_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vec_gain_comp #(.CORDIC_WIDTH(CW), .ROT_BITS(RB)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .x_in        (x_in),
    .rot_dir_in  (rot_dir_in),
    .hold        (hold),
    .in_ready    (in_ready),
    .mag_out     (mag_out),
    .rot_dir_out (rot_dir_out),
    .op_valid    (op_valid)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference 1/K from the coefficient list, using 32-bit integer arithmetic.
  function automatic int ref_mag(input int x);
    int sh [7]  = '{1, 3, 6, 9, 13, 15, 16};
    int sg [7]  = '{1, 1, -1, -1, -1, -1, -1};
    int acc = 0;
    for (int k = 0; k < 7; k++) begin
`ifdef VEC_GAIN_ROUND_EN
      acc += sg[k] * ((x + (1 << (sh[k] - 1))) >>> sh[k]);
`else
      acc += sg[k] * (x >>> sh[k]);
`endif
    end
    return acc;
  endfunction

  function automatic longint smag();
    return longint'($signed(mag_out));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input int x, input logic [RB-1:0] d);
    enable     = en;
    x_in       = CW'(x);
    rot_dir_in = d;
  endtask

  // One isolated sample: valid must rise exactly 3 edges after capture, for 1 cycle.
  task automatic send_one(input string tag, input int x, input logic [RB-1:0] d, input int exp);
    drive(1'b1, x, d);
    step();
    drive(1'b0, 0, '0);
    chk({tag, "_v1"}, longint'(op_valid), 0);
    step();
    chk({tag, "_v2"}, longint'(op_valid), 0);
    step();
    chk({tag, "_v3"}, longint'(op_valid), 1);
    chk({tag, "_mag"}, smag(), longint'(exp));
    chk({tag, "_dir"}, longint'(rot_dir_out), longint'(d));
    step();
    chk({tag, "_v4"}, longint'(op_valid), 0);
  endtask

  int sx [4] = '{1000, 2000, 3000, -777};
  logic [RB-1:0] sd [4] = '{16'hA5A5, 16'h0001, 16'hFFFF, 16'h1234};

  initial begin
    reset = 1'b1;
    hold  = 1'b0;
    drive(1'b0, 0, '0);
    step();
    chk("rst_valid", longint'(op_valid), 0);
    chk("rst_mag", smag(), 0);
    chk("rst_dir", longint'(rot_dir_out), 0);
    chk("rst_ready", longint'(in_ready), 1);
    reset = 1'b0;
    step();

    // Hand-computed vectors.
    send_one("p65536", 65536, 16'h00F0, 39797);
    send_one("n65536", -65536, 16'h0F00, -39797);
    send_one("x100", 100, 16'h0003, 61);
`ifdef VEC_GAIN_ROUND_EN
    send_one("x7", 7, 16'h8000, 5);
`else
    send_one("x7", 7, 16'h8000, 3);
`endif
    send_one("xneg", -12345, 16'h5A5A, ref_mag(-12345));
    send_one("xmax", 2097151, 16'h7FFF, ref_mag(2097151));
    send_one("xmin", -2097152, 16'hFFFE, ref_mag(-2097152));

    // Back-to-back stream: outputs on consecutive cycles, in order.
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(1'b1, sx[i], sd[i]);
      else       drive(1'b0, 0, '0);
      step();
      if (i >= 2 && i < 5) begin
        chk($sformatf("strm%0d_v", i-2), longint'(op_valid), 1);
        chk($sformatf("strm%0d_mag", i-2), smag(), longint'(ref_mag(sx[i-2])));
        chk($sformatf("strm%0d_dir", i-2), longint'(rot_dir_out), longint'(sd[i-2]));
      end
    end
    chk("strm_end_v", longint'(op_valid), 0);

    // Stall with three samples in flight; enable during hold must be dropped,
    // and the sample presented on the release edge must be accepted.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, sx[i], sd[i]);
      step();
    end
    hold = 1'b1;
    drive(1'b1, 12345, 16'hDEAD);
    #1;
    chk("hold_ready", longint'(in_ready), 0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("hold%0d_v", c), longint'(op_valid), 1);
      chk($sformatf("hold%0d_mag", c), smag(), longint'(ref_mag(sx[0])));
      chk($sformatf("hold%0d_dir", c), longint'(rot_dir_out), longint'(sd[0]));
    end
    hold = 1'b0;
    drive(1'b1, sx[3], sd[3]);
    #1;
    chk("rel_ready", longint'(in_ready), 1);
    for (int i = 1; i < 4; i++) begin
      step();
      drive(1'b0, 0, '0);
      chk($sformatf("rel%0d_v", i), longint'(op_valid), 1);
      chk($sformatf("rel%0d_mag", i), smag(), longint'(ref_mag(sx[i])));
      chk($sformatf("rel%0d_dir", i), longint'(rot_dir_out), longint'(sd[i]));
    end
    step();
    chk("rel_end_v", longint'(op_valid), 0);

    // Async reset mid-stream: outputs clear before the next clock edge.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, sx[i], sd[i]);
      step();
    end
    chk("pre_rst_v", longint'(op_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_v", longint'(op_valid), 0);
    chk("arst_mag", smag(), 0);
    chk("arst_dir", longint'(rot_dir_out), 0);
    drive(1'b0, 0, '0);
    step();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("post_rst%0d_v", c), longint'(op_valid), 0);
    end
    send_one("post_rst", 4096, 16'h0C0C, ref_mag(4096));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
